// File: rtl/mod12_wrap_tracker.sv
// Tracks a mod-12 counter: 11->0 wrap pulse, AM/PM flag, wrap count and 12-hour BCD display.
// Define MOD12_WRAP_CHECK_EN to build the sticky sequence checker that drives err.
module mod12_wrap_tracker #(
    parameter int CYCLE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         count_in,
    output logic               wrap,
    output logic               pm,
    output logic [CYCLE_W-1:0] cycles,
    output logic               hour_tens,
    output logic [3:0]         hour_ones,
    output logic               err
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] prev;
    logic [3:0] sample;
    logic       sample_vld;
    logic       legal;
    logic       is_wrap;
    logic       disp_tens;
    logic [3:0] disp_ones;

    // count_in is registered first; all decisions act on that captured sample.
    assign legal   = (sample <= 4'd11);
    assign is_wrap = (state == TRACK) && legal && (prev == 4'd11) && (sample == 4'd0);

    always_comb begin
        disp_tens = 1'b0;
        disp_ones = sample;
        if (sample == 4'd0) begin
            disp_tens = 1'b1;
            disp_ones = 4'd2;
        end else if (sample >= 4'd10) begin
            disp_tens = 1'b1;
            disp_ones = sample - 4'd10;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= INIT;
            prev       <= 4'd0;
            sample     <= 4'd0;
            sample_vld <= 1'b0;
            wrap       <= 1'b0;
            pm         <= 1'b0;
            cycles     <= '0;
            hour_tens  <= 1'b1;
            hour_ones  <= 4'd2;
        end else begin
            sample     <= count_in;
            sample_vld <= 1'b1;
            wrap       <= 1'b0;
            if (sample_vld && legal) begin
                state     <= TRACK;
                prev      <= sample;
                hour_tens <= disp_tens;
                hour_ones <= disp_ones;
                if (is_wrap) begin
                    wrap   <= 1'b1;
                    pm     <= ~pm;
                    cycles <= cycles + 1'b1;
                end
            end
        end
    end

`ifdef MOD12_WRAP_CHECK_EN
    logic step_ok;

    // Legal moves from prev: hold, count up, or drop to 0 (wrap or upstream reset).
    assign step_ok = (sample == prev) || (sample == prev + 4'd1) || (sample == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (sample_vld && (!legal || ((state == TRACK) && !step_ok))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mod12_wrap_tracker.md
# mod12_wrap_tracker

Downstream consumer of the 4-bit mod-12 counter output. Samples the counter value every clock, detects the 11→0 wrap, maintains an AM/PM flag and a cascaded wrap (cycle) count, and drives a registered 12-hour BCD display value (1..12). An optional sequence checker flags illegal counter values or illegal steps.

## Interface
- CYCLE_W, 8, width of the wrap counter `cycles`

- clk  input  1  rising-edge clock, shared with the mod-12 counter
- reset  input  1  synchronous, active-low reset
- count_in  input  4  mod-12 counter value, 0..11
- wrap  output  1  one-cycle pulse per detected 11→0 wrap
- pm  output  1  0 = AM half, 1 = PM half; toggles on each wrap
- cycles  output  CYCLE_W  number of wraps since reset, modulo 2^CYCLE_W
- hour_tens  output  1  BCD tens digit of displayed hour (0 or 1)
- hour_ones  output  4  BCD ones digit of displayed hour (0..9)
- err  output  1  sticky sequence error; only driven when the checker is compiled in

## Operation
- Internal register `prev` (4 bits) holds the last legal sample. State register has two states:
  - INIT: no valid `prev`. Entered on reset.
  - TRACK: `prev` valid.
- Legal value: count_in ≤ 11. Illegal values (12..15) never update `prev` or the display, and never cause a wrap.
- INIT, legal value: load `prev` ← count_in, update the display, go to TRACK. No wrap check and no step check on this first sample.
- TRACK, legal value:
  - Wrap when prev == 11 and count_in == 0: pulse `wrap`, toggle `pm`, increment `cycles`. `cycles` rolls 2^CYCLE_W−1 → 0 silently.
  - Always load `prev` ← count_in and update the display.
- Display mapping: count_in 0 → hour 12 (tens 1, ones 2); 1..9 → tens 0, ones = count_in; 10 → 1,0; 11 → 1,1.
- Legal steps in TRACK: count_in == prev (hold), prev+1 (count), or 0 (upstream reset or wrap).
- Reset (reset == 0 at a rising edge) has priority over every other event, including a coincident wrap:
  - state INIT, prev 0, wrap 0, pm 0, cycles 0, hour_tens 1, hour_ones 2, err 0.

## Timing
- All outputs are registered. The sample taken at edge N appears on the outputs after edge N+1 (one-cycle latency).
- `wrap` is high for exactly one cycle per wrap. Back-to-back wraps cannot occur, because a legal sequence needs at least 12 samples between wraps.
- A 0→0 hold after a wrap gives no second pulse, because `prev` is no longer 11.
- An upstream counter reset mid-count (e.g. 7→0) is legal and gives no wrap; `pm` and `cycles` are unchanged.
- Reset asserted mid-operation clears everything at the next edge. The first legal sample after release is treated as an INIT sample.

## Configuration
- MOD12_WRAP_CHECK_EN defined:
  - `err` is set, one cycle after the sample, on an illegal value in any state, or on an illegal step in TRACK.
  - `err` stays set until reset.
- MOD12_WRAP_CHECK_EN not defined:
  - `err` is tied to 0 and no checker logic is built.
  - Illegal values are still ignored as described in Operation.

## Test plan
- Reset with count_in = 5, then release → while reset is low: hour 12, pm 0, cycles 0, wrap 0. One cycle after the first sample: hour 05 (tens 0, ones 5).
- Drive 0..11, 0 → `wrap` high for exactly one cycle, one cycle after the 0 sample. pm = 1, cycles = 1. Display sequence 12,1,...,11,12.
- 26 full wraps with CYCLE_W = 8 → cycles = 26, pm = 0. Force CYCLE_W = 4 and run 16 wraps → cycles returns to 0.
- Sequence 3,4,4,0 (upstream reset) → no wrap, err stays 0, display 12 one cycle after the 0 sample.
- With MOD12_WRAP_CHECK_EN: sequence 2,5 → err = 1 one cycle after the 5 sample, and it stays 1. Then count_in = 13 → display and `prev` unchanged. Without the macro, err = 0 throughout.
- Reset asserted in the same cycle that count_in goes 11→0 → no wrap pulse, pm 0, cycles 0, hour 12.
